// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// Host-to-device PS/2 byte transmitter: inhibit, request-to-send, shift 8 data bits,
// odd parity and stop on device clock falls, then sample the device acknowledge.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned REQ_CYCLES     = 500,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);

  localparam int unsigned MAX_AB = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int unsigned MAXC   = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int          CW     = $clog2(MAXC + 1);

  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] REQ_LAST = CW'(REQ_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    k_q;
  logic [3:0]    k_d;
  logic [7:0]    data_q;
  logic          parity_q;
  logic          ack_fail_q;

  logic          clk_s1_q, clk_s2_q, clk_prev_q;
  logic          data_s1_q, data_s2_q;
  logic          fall_d;

  logic          clk_oe_q, data_oe_q, busy_q, done_q, ack_err_q, timeout_err_q;

  // Synchronizers reset to the idle (released, high) line level so reset never looks like a fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_i;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= ps2_data_i;
      data_s2_q  <= data_s1_q;
    end
  end

  assign fall_d = clk_prev_q & ~clk_s2_q;
  assign k_d    = k_q + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      k_q           <= 4'd0;
      data_q        <= 8'h00;
      parity_q      <= 1'b0;
      ack_fail_q    <= 1'b0;
      clk_oe_q      <= 1'b0;
      data_oe_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ack_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      ack_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tx_start) begin
            data_q    <= tx_data;
            parity_q  <= ~^tx_data;
            busy_q    <= 1'b1;
            clk_oe_q  <= 1'b1;
            data_oe_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (cnt_q == INH_LAST) begin
            cnt_q     <= '0;
            data_oe_q <= 1'b1;
            state_q   <= S_REQ;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_REQ: begin
          if (cnt_q == REQ_LAST) begin
            cnt_q      <= '0;
            k_q        <= 4'd0;
            ack_fail_q <= 1'b0;
            clk_oe_q   <= 1'b0;
            state_q    <= S_SEND;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_SEND, S_ACK, S_WAIT_IDLE: begin
          // The timeout window spans everything after the clock is handed to the device.
          if (cnt_q == TO_LAST) begin
            clk_oe_q      <= 1'b0;
            data_oe_q     <= 1'b0;
            done_q        <= 1'b1;
            timeout_err_q <= 1'b1;
            state_q       <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            case (state_q)
              S_SEND: begin
                if (fall_d) begin
                  k_q <= k_d;
                  if (k_d == 4'd10) begin
                    data_oe_q <= 1'b0;
                    state_q   <= S_ACK;
                  end else if (k_d == 4'd9) begin
                    data_oe_q <= ~parity_q;
                  end else begin
                    data_oe_q <= ~data_q[k_q[2:0]];
                  end
                end
              end
              S_ACK: begin
                if (fall_d) begin
                  ack_fail_q <= data_s2_q;
                  state_q    <= S_WAIT_IDLE;
                end
              end
              default: begin
                if (clk_s2_q && data_s2_q) begin
                  done_q    <= 1'b1;
                  ack_err_q <= ack_fail_q;
                  state_q   <= S_DONE;
                end
              end
            endcase
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ack_err     = ack_err_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// Bench for ps2_host_tx: open-drain line model plus a behavioural PS/2 device.
module tb_ps2_host_tx;

  localparam int HALF = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic tx_start = 1'b0;
  logic ps2_clk_pin, ps2_data_pin;
  logic ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout_err;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;

  assign ps2_clk_pin  = !(ps2_clk_oe  || dev_clk_low);
  assign ps2_data_pin = !(ps2_data_oe || dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(20),
    .REQ_CYCLES(5),
    .TIMEOUT_CYCLES(3000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .ps2_clk_i(ps2_clk_pin),
    .ps2_data_i(ps2_data_pin),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy(busy),
    .done(done),
    .ack_err(ack_err),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle-level observer, sampled on the falling clock edge.
  int   cyc = 0;
  int   rise_cyc, clk_oe_len, data_rise_off, rel_cyc, rel_cnt, done_cyc, done_cnt, busy_rises;
  logic last_ack, last_to, busy_at_done, busy_after_done, oe_at_done;
  logic clk_oe_prev = 1'b0, data_oe_prev = 1'b0, done_prev = 1'b0, busy_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (ps2_clk_oe && !clk_oe_prev) rise_cyc = cyc;
    if (!ps2_clk_oe && clk_oe_prev) begin
      clk_oe_len = cyc - rise_cyc;
      rel_cyc = cyc;
      rel_cnt++;
    end
    if (ps2_data_oe && !data_oe_prev && ps2_clk_oe) data_rise_off = cyc - rise_cyc;
    if (busy && !busy_prev) busy_rises++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      last_ack = ack_err;
      last_to = timeout_err;
      busy_at_done = busy;
      oe_at_done = ps2_clk_oe | ps2_data_oe;
    end
    if (done_prev) busy_after_done = busy;
    clk_oe_prev = ps2_clk_oe;
    data_oe_prev = ps2_data_oe;
    done_prev = done;
    busy_prev = busy;
  end

  task automatic clear_obs();
    clk_oe_len = -1; data_rise_off = -1; rel_cnt = 0; done_cnt = 0; busy_rises = 0;
    last_ack = 1'bx; last_to = 1'bx; busy_at_done = 1'bx; busy_after_done = 1'bx;
    oe_at_done = 1'bx;
  endtask

  // Reference frame as seen by the device: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    int ones = 0;
    logic [10:0] f;
    for (int i = 0; i < 8; i++) ones += int'((b >> i) & 8'h01);
    f = 11'd0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9] = (ones % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // Device: samples data while its clock is high, issues up to 11 falls, acks on the 11th.
  task automatic dev_frame(input bit ack, input int nfalls, output logic [10:0] bits);
    bits = '1;
    for (int i = 0; i < 11; i++) begin
      #(HALF);
      bits[i] = ps2_data_pin;
      if (i < 10) begin
        dev_clk_low = 1'b1;
        if (i + 1 == nfalls) return;
        #(HALF);
        dev_clk_low = 1'b0;
      end
    end
    #(HALF / 2);
    dev_data_low = ack;
    #(HALF / 2);
    dev_clk_low = 1'b1;
    #(HALF);
    dev_clk_low = 1'b0;
    #(HALF / 2);
    dev_data_low = 1'b0;
  endtask

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    tx_data = b;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data = 8'($urandom);
    chk("busy_on_accept", busy, 1);
    chk("clk_oe_on_accept", ps2_clk_oe, 1);
  endtask

  task automatic wait_release();
    for (int n = 0; n < 200 && rel_cnt == 0; n++) @(negedge clk);
    chk("clk_released", rel_cnt > 0, 1);
  endtask

  task automatic wait_done(input int budget);
    for (int n = 0; n < budget && done_cnt == 0; n++) @(negedge clk);
    chk("done_seen", done_cnt > 0, 1);
  endtask

  task automatic run_xfer(input logic [7:0] b, input bit ack, input bit inject);
    logic [10:0] bits;
    clear_obs();
    start_tx(b);
    wait_release();
    fork
      dev_frame(ack, 11, bits);
      if (inject) begin
        #(5 * HALF);
        @(negedge clk);
        tx_data = 8'hFF;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        for (int n = 0; n < 5000 && !done; n++) @(negedge clk);
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    wait_done(1000);
    repeat (inject ? 50 : 5) @(negedge clk);
    chk("frame_bits", bits, model_frame(b));
    chk("done_pulses", done_cnt, 1);
    chk("ack_err", last_ack, !ack);
    chk("timeout_err", last_to, 0);
    chk("clk_oe_len", clk_oe_len, 25);
    chk("data_oe_rise", data_rise_off, 20);
    chk("busy_at_done", busy_at_done, 1);
    chk("busy_after_done", busy_after_done, 0);
    chk("accepts", busy_rises, 1);
  endtask

  initial begin
    logic [10:0] part;
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ack_err", ack_err, 0);
    chk("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    run_xfer(8'hED, 1'b1, 1'b0);
    run_xfer(8'h02, 1'b1, 1'b0);
    run_xfer(8'($urandom), 1'b0, 1'b0);

    // Silent device: expect a timeout exactly 3000 cycles after clock release.
    clear_obs();
    start_tx(8'($urandom));
    wait_release();
    wait_done(4000);
    repeat (3) @(negedge clk);
    chk("timeout_latency", done_cyc - rel_cyc, 3000);
    chk("timeout_flag", last_to, 1);
    chk("timeout_no_ack_err", last_ack, 0);
    chk("timeout_oes_off", oe_at_done, 0);
    chk("timeout_busy_after", busy_after_done, 0);
    run_xfer(8'($urandom), 1'b1, 1'b0);

    run_xfer(8'h5A, 1'b1, 1'b1);

    // Reset in the middle of a frame, right after the device's 5th clock fall.
    clear_obs();
    start_tx(8'hED);
    wait_release();
    dev_frame(1'b1, 5, part);
    #300;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_clk_oe", ps2_clk_oe, 0);
    chk("arst_data_oe", ps2_data_oe, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    dev_clk_low = 1'b0;
    dev_data_low = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    run_xfer(8'hED, 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) run_xfer(8'($urandom), 1'($urandom_range(0, 1)), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
